// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter stage.
package pc_pkg;

    localparam int ADDR_W = 32;
    localparam int JIDX_W = 26;
    localparam int OFFS_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } pc_state_e;

    // Plain constants so the state register stays a simple logic vector.
    localparam logic [1:0] ST_BOOT = BOOT;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_HOLD = HOLD;
    localparam logic [1:0] ST_HALT = HALT;

endpackage

// File: rtl/pc_target_sel.sv
// Combinational redirect selection: computes branch/jump targets and picks the
// highest-priority live redirect (jr > j > branch).
module pc_target_sel
    import pc_pkg::*;
(
    input  logic [ADDR_W-1:0] npc,
    input  logic              br_taken,
    input  logic [OFFS_W-1:0] br_offset,
    input  logic              j_en,
    input  logic [JIDX_W-1:0] j_index,
    input  logic              jr_en,
    input  logic [ADDR_W-1:0] jr_target,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_target
);

    localparam int NSRC = 3;

    logic [NSRC-1:0]   req;
    logic [NSRC-1:0]   grant;
    logic [ADDR_W-1:0] tgt    [NSRC];
    logic [ADDR_W-1:0] masked [NSRC];

    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;

    assign br_target = npc + {{(ADDR_W-OFFS_W){br_offset[OFFS_W-1]}}, br_offset};
    assign j_target  = {npc[ADDR_W-1:JIDX_W], j_index};

    // Index 0 is the highest priority source.
    assign req[0] = jr_en;
    assign req[1] = j_en;
    assign req[2] = br_taken;
    assign tgt[0] = jr_target;
    assign tgt[1] = j_target;
    assign tgt[2] = br_target;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_grant
            if (gi == 0) begin : g_first
                assign grant[gi] = req[gi];
            end else begin : g_rest
                assign grant[gi] = req[gi] & ~(|req[gi-1:0]);
            end
            assign masked[gi] = {ADDR_W{grant[gi]}} & tgt[gi];
        end
    endgenerate

    always_comb begin
        redirect_target = '0;
        for (int i = 0; i < NSRC; i++) begin
            redirect_target = redirect_target | masked[i];
        end
    end

    assign redirect = |req;

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, fetch handshake FSM and a one-entry
// buffer for redirects that arrive while the PC cannot advance.
module pc_unit
    import pc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] npc,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [OFFS_W-1:0] br_offset,
    input  logic              j_en,
    input  logic [JIDX_W-1:0] j_index,
    input  logic              jr_en,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              halt_req,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_valid,
    output logic              redirect_pending,
    output logic              halted
);

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              pend_reg, pend_next;
    logic [ADDR_W-1:0] ptgt_reg, ptgt_next;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic              adv;

    pc_target_sel u_target_sel (
        .npc             (npc),
        .br_taken        (br_taken),
        .br_offset       (br_offset),
        .j_en            (j_en),
        .j_index         (j_index),
        .jr_en           (jr_en),
        .jr_target       (jr_target),
        .redirect        (redirect),
        .redirect_target (redirect_target)
    );

    assign fetch_valid      = (state_reg == ST_RUN) || (state_reg == ST_HOLD);
    assign halted           = (state_reg == ST_HALT);
    assign redirect_pending = pend_reg;
    assign pc               = pc_reg;
    assign adv              = fetch_valid & imem_ready & ~stall;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        pend_next  = pend_reg;
        ptgt_next  = ptgt_reg;
        case (state_reg)
            ST_BOOT: begin
                state_next = ST_RUN;
            end
            ST_RUN, ST_HOLD: begin
                if (halt_req) begin
                    state_next = ST_HALT;
                    pend_next  = 1'b0;
                end else if (adv) begin
                    // A live redirect supersedes anything buffered earlier.
                    if (redirect) begin
                        pc_next = redirect_target;
                    end else if (pend_reg) begin
                        pc_next = ptgt_reg;
                    end else begin
                        pc_next = npc;
                    end
                    pend_next  = 1'b0;
                    state_next = ST_RUN;
                end else begin
                    if (redirect) begin
                        pend_next = 1'b1;
                        ptgt_next = redirect_target;
                    end
                    state_next = stall ? ST_HOLD : ST_RUN;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_BOOT;
            pc_reg    <= RESET_PC;
            pend_reg  <= 1'b0;
            ptgt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            pend_reg  <= pend_next;
            ptgt_reg  <= ptgt_next;
        end
    end

endmodule
